// File: rtl/keypad_row_decoder.sv
// 4x4 keypad row reader: synchronises and debounces the row lines, freezes the column
// scanner while a key is being qualified or held, and reports each accepted press once.
module keypad_row_decoder #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] col_idx,
    input  logic [3:0] rows,
    output logic       hold,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] key_digit,
    output logic       key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_lat;
    logic [1:0]       col_lat;
    logic [3:0]       rows_m;
    logic [3:0]       rows_s;
    logic [1:0]       pri_idx;

    // Row 0 has the highest priority when several rows are active at once.
    always_comb begin
        pri_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows_s[i]) pri_idx = 2'(i);
        end
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] d;
        case ({r, c})
            4'b00_00: d = 4'h1;
            4'b00_01: d = 4'h2;
            4'b00_10: d = 4'h3;
            4'b00_11: d = 4'hA;
            4'b01_00: d = 4'h4;
            4'b01_01: d = 4'h5;
            4'b01_10: d = 4'h6;
            4'b01_11: d = 4'hB;
            4'b10_00: d = 4'h7;
            4'b10_01: d = 4'h8;
            4'b10_10: d = 4'h9;
            4'b10_11: d = 4'hC;
            4'b11_00: d = 4'hE;
            4'b11_01: d = 4'h0;
            4'b11_10: d = 4'hF;
            default:  d = 4'hD;
        endcase
        return d;
    endfunction

    // key_valid is a one-cycle pulse with no back-pressure: the consumer must take
    // key_code/key_digit in the same cycle; both stay stable until the next accepted press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            row_lat   <= 2'd0;
            col_lat   <= 2'd0;
            rows_m    <= 4'd0;
            rows_s    <= 4'd0;
            hold      <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_digit <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            // Status outputs follow the state register, so they trail a transition by one cycle.
            hold      <= (state != IDLE);
            key_held  <= (state == PRESSED) || (state == RELEASE);

            case (state)
                IDLE: begin
                    if (|rows_s) begin
                        row_lat <= pri_idx;
                        col_lat <= col_idx;
                        cnt     <= '0;
                        state   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // A scanner step before hold took effect makes the latched column stale.
                    if (!rows_s[row_lat] || (col_idx != col_lat)) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        key_valid <= 1'b1;
                        key_code  <= {row_lat, col_lat};
                        key_digit <= key_map(row_lat, col_lat);
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!rows_s[row_lat]) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (rows_s[row_lat]) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Directed bench for keypad_row_decoder with an 8-cycle debounce window; every check
// is an immediate assertion against a hand-derived value.
module tb_keypad_row_decoder;

    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] col_idx;
    logic [3:0] rows;
    logic       hold;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] key_digit;
    logic       key_held;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    keypad_row_decoder #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_idx   (col_idx),
        .rows      (rows),
        .hold      (hold),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_digit (key_digit),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Counts every cycle in which key_valid is high.
    always @(negedge clk) begin
        if (key_valid === 1'b1) pulse_cnt++;
    end

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rows    = 4'd0;
        col_idx = 2'd0;
        tick(2);
        chk("rst_hold",  32'(hold),      32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code",  32'(key_code),  32'd0);
        chk("rst_digit", 32'(key_digit), 32'd0);
        chk("rst_held",  32'(key_held),  32'd0);
        reset = 1'b0;
        tick(1);

        // 1: clean press of row1/col2
        col_idx = 2'd2;
        rows    = 4'b0010;
        tick(3);
        chk("t1_hold_e3", 32'(hold), 32'd0);
        tick(1);
        chk("t1_hold_e4", 32'(hold), 32'd1);
        tick(6);
        chk("t1_valid_e10", 32'(key_valid), 32'd0);
        tick(1);
        chk("t1_valid_e11", 32'(key_valid), 32'd1);
        chk("t1_code",  32'(key_code),  32'h6);
        chk("t1_digit", 32'(key_digit), 32'h6);
        tick(1);
        chk("t1_valid_e12", 32'(key_valid), 32'd0);
        chk("t1_held",      32'(key_held),  32'd1);
        tick(28);
        chk("t1_pulses", 32'(pulse_cnt), 32'd1);

        // 3: release bounce, then a steady release
        rows = 4'b0000;
        tick(4);
        rows = 4'b0010;
        tick(10);
        chk("t3_held_bounce", 32'(key_held),  32'd1);
        chk("t3_pulses",      32'(pulse_cnt), 32'd1);
        chk("t3_code_kept",   32'(key_code),  32'h6);
        rows = 4'b0000;
        tick(11);
        chk("t3_hold_f11", 32'(hold), 32'd1);
        tick(1);
        chk("t3_hold_f12",  32'(hold),      32'd0);
        chk("t3_held_off",  32'(key_held),  32'd0);
        chk("t3_code_idle", 32'(key_code),  32'h6);
        chk("t3_digit_idle", 32'(key_digit), 32'h6);

        // 2: bouncy press of row0/col1, then steady
        col_idx = 2'd1;
        for (int i = 0; i < 20; i++) begin
            rows = ((i / 3) % 2 == 0) ? 4'b0000 : 4'b0001;
            tick(1);
        end
        chk("t2_no_bounce_pulse", 32'(pulse_cnt), 32'd1);
        rows = 4'b0001;
        tick(10);
        chk("t2_valid_s10", 32'(key_valid), 32'd0);
        tick(1);
        chk("t2_valid_s11", 32'(key_valid), 32'd1);
        chk("t2_code",  32'(key_code),  32'h1);
        chk("t2_digit", 32'(key_digit), 32'h2);
        tick(5);
        chk("t2_pulses", 32'(pulse_cnt), 32'd2);
        rows = 4'b0000;
        tick(14);
        chk("t2_hold_off", 32'(hold), 32'd0);

        // 4: two rows at once; row2 wins, row3 is ignored while held
        col_idx = 2'd0;
        rows    = 4'b1100;
        tick(11);
        chk("t4_valid", 32'(key_valid), 32'd1);
        chk("t4_code",  32'(key_code),  32'h8);
        chk("t4_digit", 32'(key_digit), 32'h7);
        tick(5);
        rows = 4'b1000;
        tick(4);
        rows = 4'b1100;
        tick(10);
        chk("t4_pulses",    32'(pulse_cnt), 32'd3);
        chk("t4_held",      32'(key_held),  32'd1);
        chk("t4_code_kept", 32'(key_code),  32'h8);
        rows = 4'b0000;
        tick(14);
        chk("t4_hold_off", 32'(hold), 32'd0);

        // 5: column slips during debounce
        col_idx = 2'd1;
        rows    = 4'b0001;
        tick(4);
        col_idx = 2'd2;
        tick(1);
        chk("t5_hold_e5", 32'(hold), 32'd1);
        tick(1);
        chk("t5_hold_e6", 32'(hold), 32'd0);
        rows = 4'b0000;
        tick(12);
        chk("t5_pulses", 32'(pulse_cnt), 32'd3);
        chk("t5_code",   32'(key_code),  32'h8);
        chk("t5_hold_idle", 32'(hold),   32'd0);

        // 6: reset during debounce and during a held key
        col_idx = 2'd3;
        rows    = 4'b0001;
        tick(6);
        reset = 1'b1;
        tick(1);
        chk("t6a_hold",  32'(hold),      32'd0);
        chk("t6a_valid", 32'(key_valid), 32'd0);
        chk("t6a_code",  32'(key_code),  32'd0);
        chk("t6a_digit", 32'(key_digit), 32'd0);
        chk("t6a_held",  32'(key_held),  32'd0);
        reset = 1'b0;
        tick(4);
        chk("t6_valid_e11", 32'(key_valid), 32'd0);
        tick(6);
        chk("t6_valid_e17", 32'(key_valid), 32'd0);
        chk("t6_pulses_pre", 32'(pulse_cnt), 32'd3);
        tick(1);
        chk("t6_valid_e18", 32'(key_valid), 32'd1);
        chk("t6_code",  32'(key_code),  32'h3);
        chk("t6_digit", 32'(key_digit), 32'hA);
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("t6b_hold",  32'(hold),      32'd0);
        chk("t6b_code",  32'(key_code),  32'd0);
        chk("t6b_digit", 32'(key_digit), 32'd0);
        chk("t6b_held",  32'(key_held),  32'd0);
        reset = 1'b0;
        rows  = 4'b0000;
        tick(5);
        chk("t6_pulses_total", 32'(pulse_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
